// File: rtl/pulse_filter_buffer_ctrl_pkg.sv
// Shared constants and types for the pulse-filter line-buffer sequencer.
// The sizes must match the generated 4 x 10b x 3072 dual-port RAM cores.
package pulse_filter_buffer_ctrl_pkg;

   localparam int BUF_NUM    = 4;
   localparam int DATA_WIDTH = 10;
   localparam int ADDR_WIDTH = 12;
   localparam int LINE_MAX   = 3072;
   localparam int RD_LATENCY = 1;
   localparam int DLY_DEPTH  = RD_LATENCY + 1;
   localparam int PTR_WIDTH  = 2;
   localparam int CNT_FULL   = 3;

   typedef logic [PTR_WIDTH-1:0]  bufPtr_t;
   typedef logic [ADDR_WIDTH-1:0] colAddr_t;
   typedef logic [1:0]            lineCnt_t;

   typedef struct packed {
      logic                  fval;
      logic                  lval;
      logic [DATA_WIDTH-1:0] pix;
   } alignBeat_t;

   // Buffers holding lines n-1, n-2, n-3 relative to the one being written.
   function automatic logic [3*PTR_WIDTH-1:0] rowOrder(input bufPtr_t ptr);
      return {ptr - bufPtr_t'(3), ptr - bufPtr_t'(2), ptr - bufPtr_t'(1)};
   endfunction

endpackage

// File: rtl/pulse_filter_buffer_ctrl_delay_line.sv
// Fixed-depth shift register that keeps the live pixel stream aligned with
// the RAM read data of the previous lines.
module pulse_filter_delay_line #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pulse_filter_buffer_ctrl.sv
// Write/read sequencer for the pulse-filter line buffer: writes the current
// line into one RAM, reads the other three at the same column.
module pulse_filter_buffer_ctrl
   import pulse_filter_buffer_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_fval,
   input  logic                  i_lval,
   input  logic [DATA_WIDTH-1:0] iv_pix_data,
   output logic [BUF_NUM-1:0]    ov_buffer_wr_en,
   output logic [ADDR_WIDTH-1:0] ov_buffer_wr_addr,
   output logic [DATA_WIDTH-1:0] ov_buffer_wr_din,
   output logic                  o_reset_buffer,
   output logic [BUF_NUM-1:0]    ov_buffer_rd_en,
   output logic [ADDR_WIDTH-1:0] ov_buffer_rd_addr,
   output logic [5:0]            ov_row_order,
   output logic                  o_lines_ready,
   output logic                  o_fval_dly,
   output logic                  o_lval_dly,
   output logic [DATA_WIDTH-1:0] ov_pix_dly,
   output logic                  o_line_overflow
);

   localparam logic [BUF_NUM-1:0] ONE_HOT_BASE = BUF_NUM'(1);

   logic                  pixValid, frameStart, lineEnd;
   logic                  fvalPrev_q, pixValidPrev_q;
   bufPtr_t               basePtr, wrPtr_q, wrPtr_d;
   colAddr_t              baseCol, col_q, col_d;
   lineCnt_t              baseCnt, lineCnt_q, lineCnt_d;
   logic [BUF_NUM-1:0]    wrEn_q, wrEn_d, rdEn_q, rdEn_d;
   colAddr_t              addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wrDin_q, wrDin_d;
   logic                  overflow_q, overflow_d;
   logic                  resetBuf_q, linesReady_q;
   logic [5:0]            rowOrder_q;
   alignBeat_t            beatIn, beatOut;

   // A frame start overrides any line end seen in the same cycle.
   always_comb begin
      pixValid   = i_fval & i_lval;
      frameStart = i_fval & ~fvalPrev_q;
      lineEnd    = pixValidPrev_q & ~pixValid;
      basePtr    = frameStart ? '0 : wrPtr_q;
      baseCol    = frameStart ? '0 : col_q;
      baseCnt    = frameStart ? '0 : lineCnt_q;
      wrPtr_d    = basePtr;
      col_d      = baseCol;
      lineCnt_d  = baseCnt;
      overflow_d = frameStart ? 1'b0 : overflow_q;
      wrEn_d     = '0;
      rdEn_d     = '0;
      addr_d     = addr_q;
      wrDin_d    = wrDin_q;
      if (pixValid) begin
         if (baseCol < colAddr_t'(LINE_MAX)) begin
            wrEn_d  = ONE_HOT_BASE << basePtr;
            rdEn_d  = ~(ONE_HOT_BASE << basePtr);
            addr_d  = baseCol;
            wrDin_d = iv_pix_data;
            col_d   = baseCol + colAddr_t'(1);
         end else begin
            overflow_d = 1'b1;
         end
      end else if (lineEnd && !frameStart) begin
         wrPtr_d   = wrPtr_q + bufPtr_t'(1);
         col_d     = '0;
         lineCnt_d = (lineCnt_q == lineCnt_t'(CNT_FULL)) ? lineCnt_q : lineCnt_q + lineCnt_t'(1);
      end
   end

   // fvalPrev resets high so an fval already asserted at reset release is
   // not taken as a frame start; that line is simply written at pointer 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fvalPrev_q     <= 1'b1;
         pixValidPrev_q <= 1'b0;
         wrPtr_q        <= '0;
         col_q          <= '0;
         lineCnt_q      <= '0;
         wrEn_q         <= '0;
         rdEn_q         <= '0;
         addr_q         <= '0;
         wrDin_q        <= '0;
         overflow_q     <= 1'b0;
         resetBuf_q     <= 1'b0;
         linesReady_q   <= 1'b0;
         rowOrder_q     <= '0;
      end else begin
         fvalPrev_q     <= i_fval;
         pixValidPrev_q <= pixValid;
         wrPtr_q        <= wrPtr_d;
         col_q          <= col_d;
         lineCnt_q      <= lineCnt_d;
         wrEn_q         <= wrEn_d;
         rdEn_q         <= rdEn_d;
         addr_q         <= addr_d;
         wrDin_q        <= wrDin_d;
         overflow_q     <= overflow_d;
         resetBuf_q     <= frameStart;
         linesReady_q   <= (lineCnt_d == lineCnt_t'(CNT_FULL));
         rowOrder_q     <= rowOrder(wrPtr_d);
      end
   end

   assign beatIn = '{fval: i_fval, lval: i_lval, pix: iv_pix_data};

   pulse_filter_delay_line #(
      .WIDTH($bits(alignBeat_t)),
      .DEPTH(DLY_DEPTH)
   ) u_delay_line (
      .clk   (clk),
      .reset (reset),
      .din_i (beatIn),
      .dout_o(beatOut)
   );

   assign ov_buffer_wr_en   = wrEn_q;
   assign ov_buffer_wr_addr = addr_q;
   assign ov_buffer_wr_din  = wrDin_q;
   assign ov_buffer_rd_en   = rdEn_q;
   assign ov_buffer_rd_addr = addr_q;
   assign o_reset_buffer    = resetBuf_q;
   assign ov_row_order      = rowOrder_q;
   assign o_lines_ready     = linesReady_q;
   assign o_line_overflow   = overflow_q;
   assign o_fval_dly        = beatOut.fval;
   assign o_lval_dly        = beatOut.lval;
   assign ov_pix_dly        = beatOut.pix;

endmodule
